// File: rtl/bus_pack_datapath_pkg.sv
// Shared definitions for bus_pack_datapath: element size encoding and the
// width-derivation helpers used to size the packer select/size ports.
package bus_pack_datapath_pkg;

  typedef enum logic [2:0] {
    SIZE_1  = 3'd0,
    SIZE_2  = 3'd1,
    SIZE_4  = 3'd2,
    SIZE_8  = 3'd3,
    SIZE_16 = 3'd4,
    SIZE_32 = 3'd5
  } size_e;

  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

  // Byte-offset select width for an in_w-bit source word.
  function automatic int sel_width(input int in_w);
    return clog2_min1(in_w / 8);
  endfunction

  function automatic int size_width(input int sel_w);
    return clog2_min1(sel_w);
  endfunction

  // Size code that denotes the whole source word.
  function automatic int full_size(input int in_w);
    return $clog2(in_w / 8);
  endfunction

endpackage

// File: rtl/bus_pack_replicate.sv
// Combinational packer: byte-shifts the source word, keeps an element of
// 2^size bytes and replicates it across the output bus.
module bus_pack_replicate
  import bus_pack_datapath_pkg::*;
#(
  parameter int in_width_p  = 64,
  parameter int out_width_p = 64,
  parameter int sel_w       = sel_width(64),
  parameter int size_w      = size_width(sel_width(64))
) (
  input  logic [in_width_p-1:0]  data_i,
  input  logic [sel_w-1:0]       sel_i,
  input  logic [size_w-1:0]      size_i,
  output logic [out_width_p-1:0] data_o
);

  localparam int full_lp = full_size(in_width_p);

  logic [in_width_p-1:0]  shifted_s;
  logic [out_width_p-1:0] rep_s [full_lp+1];
  int                     size_idx_s;

  assign shifted_s = data_i >> {sel_i, 3'b000};

  for (genvar s = 0; s <= full_lp; s++) begin : g_size
    localparam int eb_lp = 8 << s;
    for (genvar k = 0; k < out_width_p / eb_lp; k++) begin : g_rep
      assign rep_s[s][k*eb_lp +: eb_lp] = shifted_s[eb_lp-1:0];
    end
  end

  // Oversized size codes fall through to the full-word replication.
  always_comb begin
    size_idx_s = 32'(size_i);
    data_o     = rep_s[full_lp];
    for (int s = 0; s <= full_lp; s++) begin
      if (size_idx_s == s) begin
        data_o = rep_s[s];
      end else begin
        data_o = data_o;
      end
    end
  end

endmodule

// File: rtl/bus_pack_datapath.sv
// Loader datapath: bus packer, clear/up command counter and enabled capture
// register. Optional simulation checks are enabled by BUS_PACK_DATAPATH_ASSERT_EN.
module bus_pack_datapath
  import bus_pack_datapath_pkg::*;
#(
  parameter int in_width_p      = 64,
  parameter int out_width_p     = 64,
  parameter int max_val_p       = (1 << 24) - 1,
  parameter int init_val_p      = 0,
  parameter int reg_width_p     = 64,
  parameter logic [reg_width_p-1:0] reg_reset_val_p = '0,
  localparam int sel_w  = sel_width(in_width_p),
  localparam int size_w = size_width(sel_w),
  localparam int cnt_w  = clog2_min1(max_val_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [in_width_p-1:0]  pack_data_i,
  input  logic [sel_w-1:0]       pack_sel_i,
  input  logic [size_w-1:0]      pack_size_i,
  output logic [out_width_p-1:0] pack_data_o,
  input  logic                   cnt_clear_i,
  input  logic                   cnt_up_i,
  output logic [cnt_w-1:0]       cnt_o,
  input  logic                   reg_en_i,
  input  logic [reg_width_p-1:0] reg_data_i,
  output logic [reg_width_p-1:0] reg_data_o
);

  logic [cnt_w-1:0]       cnt_q, cnt_d;
  logic [reg_width_p-1:0] reg_q, reg_d;

  bus_pack_replicate #(
    .in_width_p (in_width_p),
    .out_width_p(out_width_p),
    .sel_w      (sel_w),
    .size_w     (size_w)
  ) u_pack (
    .data_i(pack_data_i),
    .sel_i (pack_sel_i),
    .size_i(pack_size_i),
    .data_o(pack_data_o)
  );

  // Counter next state; increments past max wrap modulo 2^cnt_w.
  always_comb begin
    cnt_d = (cnt_clear_i ? {cnt_w{1'b0}} : cnt_q) + cnt_w'(cnt_up_i);
  end

  // Register next state.
  always_comb begin
    if (reg_en_i) begin
      reg_d = reg_data_i;
    end else begin
      reg_d = reg_q;
    end
  end

  // State update; reset dominates clear, up and enable.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= cnt_w'(init_val_p);
      reg_q <= reg_reset_val_p;
    end else begin
      cnt_q <= cnt_d;
      reg_q <= reg_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign reg_data_o = reg_q;

`ifdef BUS_PACK_DATAPATH_ASSERT_EN
  if (out_width_p % in_width_p != 0) begin : g_bad_out_width
    $error("out_width_p (%0d) is not a multiple of in_width_p (%0d)", out_width_p, in_width_p);
  end
  if ((in_width_p & (in_width_p - 1)) != 0) begin : g_bad_in_width
    $error("in_width_p (%0d) is not a power of two", in_width_p);
  end

  // Usage checks, silent while reset is held.
  always @(posedge clk_i) begin
    if (!reset_i) begin
      if (cnt_up_i && !cnt_clear_i && (cnt_q == cnt_w'(max_val_p))) begin
        $error("counter incremented at max_val_p");
      end
      if ((32'(pack_sel_i) & ((32'd1 << pack_size_i) - 32'd1)) != 32'd0) begin
        $error("pack_sel_i %0d misaligned for size code %0d", pack_sel_i, pack_size_i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bus_pack_datapath.sv
// Self-checking bench: directed literal checks plus randomized traffic compared
// against a behavioural model, on a 64->64 instance and a 64->128, max=7 instance.
module tb_bus_pack_datapath;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [63:0]  pack_data_i;
  logic [2:0]   pack_sel_i;
  logic [1:0]   pack_size_i;
  logic         cnt_clear_i, cnt_up_i, reg_en_i;
  logic [63:0]  reg_data_i;

  logic [63:0]  pack0_o, reg0_o, reg1_o;
  logic [127:0] pack1_o;
  logic [23:0]  cnt0_o;
  logic [2:0]   cnt1_o;

  int checks = 0;
  int errors = 0;

  // Model state
  longint unsigned m_cnt0, m_cnt1;
  logic [63:0]     m_reg;

  always #5 clk = ~clk;

  bus_pack_datapath dut0 (
    .clk_i(clk), .reset_i(reset_i),
    .pack_data_i(pack_data_i), .pack_sel_i(pack_sel_i), .pack_size_i(pack_size_i),
    .pack_data_o(pack0_o),
    .cnt_clear_i(cnt_clear_i), .cnt_up_i(cnt_up_i), .cnt_o(cnt0_o),
    .reg_en_i(reg_en_i), .reg_data_i(reg_data_i), .reg_data_o(reg0_o)
  );

  bus_pack_datapath #(.out_width_p(128), .max_val_p(7)) dut1 (
    .clk_i(clk), .reset_i(reset_i),
    .pack_data_i(pack_data_i), .pack_sel_i(pack_sel_i), .pack_size_i(pack_size_i),
    .pack_data_o(pack1_o),
    .cnt_clear_i(cnt_clear_i), .cnt_up_i(cnt_up_i), .cnt_o(cnt1_o),
    .reg_en_i(reg_en_i), .reg_data_i(reg_data_i), .reg_data_o(reg1_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_model(input logic [63:0] d, input int sel,
                                              input int size, input int out_w);
    int           eb;
    logic [127:0] sh, elem, res;
    eb   = 8 << ((size > 3) ? 3 : size);
    sh   = {64'd0, d} >> (8 * sel);
    elem = sh & ((128'd1 << eb) - 128'd1);
    res  = '0;
    for (int i = 0; i < out_w / eb; i++) res = res | (elem << (i * eb));
    return res;
  endfunction

  // One clock edge: advance the model with the inputs the DUT samples.
  task automatic cycle();
    @(posedge clk);
    if (reset_i) begin
      m_cnt0 = 0;
      m_cnt1 = 0;
      m_reg  = 64'd0;
    end else begin
      m_cnt0 = ((cnt_clear_i ? 0 : m_cnt0) + cnt_up_i) % (64'd1 << 24);
      m_cnt1 = ((cnt_clear_i ? 0 : m_cnt1) + cnt_up_i) % 64'd8;
      if (reg_en_i) m_reg = reg_data_i;
    end
    #1;
  endtask

  task automatic compare_all();
    check("pack0", {64'd0, pack0_o}, pack_model(pack_data_i, pack_sel_i, pack_size_i, 64));
    check("pack1", pack1_o, pack_model(pack_data_i, pack_sel_i, pack_size_i, 128));
    check("cnt0", {104'd0, cnt0_o}, 128'(m_cnt0));
    check("cnt1", {125'd0, cnt1_o}, 128'(m_cnt1));
    check("reg0", {64'd0, reg0_o}, {64'd0, m_reg});
    check("reg1", {64'd0, reg1_o}, {64'd0, m_reg});
  endtask

  typedef struct {
    int          size;
    int          sel;
    logic [63:0] exp;
  } pack_vec_t;

  pack_vec_t pvec [5] = '{
    '{0, 0, 64'hEFEFEFEFEFEFEFEF},
    '{1, 2, 64'h89AB89AB89AB89AB},
    '{2, 4, 64'h0123456701234567},
    '{3, 0, 64'h0123456789ABCDEF},
    '{1, 7, 64'h0001000100010001}
  };

  initial begin
    reset_i = 1'b1; cnt_clear_i = 1'b0; cnt_up_i = 1'b0; reg_en_i = 1'b0;
    reg_data_i = 64'd0; pack_data_i = 64'h0123456789ABCDEF;
    pack_sel_i = 3'd0; pack_size_i = 2'd0;
    m_cnt0 = 0; m_cnt1 = 0; m_reg = 64'd0;
    #2;
    cycle();
    check("reset_cnt", {104'd0, cnt0_o}, 128'd0);
    check("reset_reg", {64'd0, reg0_o}, 128'd0);
    reset_i = 1'b0;

    // Packer literals
    foreach (pvec[i]) begin
      pack_size_i = pvec[i].size[1:0];
      pack_sel_i  = pvec[i].sel[2:0];
      #1;
      check($sformatf("pack_lit%0d", i), {64'd0, pack0_o}, {64'd0, pvec[i].exp});
      check($sformatf("pack_model%0d", i), pack_model(pack_data_i, pvec[i].sel, pvec[i].size, 64),
            {64'd0, pvec[i].exp});
    end
    pack_size_i = 2'd3; pack_sel_i = 3'd0; #1;
    check("pack128_lit", pack1_o, 128'h0123456789ABCDEF0123456789ABCDEF);

    // Counter sequence
    cnt_up_i = 1'b1;
    repeat (3) cycle();
    check("cnt_up3", {104'd0, cnt0_o}, 128'd3);
    cnt_clear_i = 1'b1; cycle();
    check("cnt_clear_up", {104'd0, cnt0_o}, 128'd1);
    cnt_up_i = 1'b0; cycle();
    check("cnt_clear", {104'd0, cnt0_o}, 128'd0);
    cnt_clear_i = 1'b0; cycle();
    check("cnt_hold", {104'd0, cnt0_o}, 128'd0);
    cnt_up_i = 1'b1;
    repeat (5) cycle();
    check("cnt_five", {104'd0, cnt0_o}, 128'd5);
    reset_i = 1'b1; cycle();
    check("cnt_mid_reset", {104'd0, cnt0_o}, 128'd0);
    reset_i = 1'b0; cycle();
    check("cnt_after_reset", {104'd0, cnt0_o}, 128'd1);
    cnt_up_i = 1'b0; cnt_clear_i = 1'b1; cycle();
    cnt_clear_i = 1'b0; cnt_up_i = 1'b1;
    repeat (7) cycle();
    check("cnt1_at_max", {125'd0, cnt1_o}, 128'd7);
    cycle();
    check("cnt1_wrap", {125'd0, cnt1_o}, 128'd0);
    check("cnt0_no_wrap", {104'd0, cnt0_o}, 128'd8);
    cnt_up_i = 1'b0;

    // Register sequence
    reg_en_i = 1'b1; reg_data_i = 64'hDEADBEEF; cycle();
    check("reg_load", {64'd0, reg0_o}, 128'hDEADBEEF);
    reg_en_i = 1'b0; reg_data_i = 64'h12345678; cycle();
    check("reg_hold", {64'd0, reg0_o}, 128'hDEADBEEF);
    reg_en_i = 1'b1; reset_i = 1'b1; cycle();
    check("reg_reset_en", {64'd0, reg0_o}, 128'd0);
    reset_i = 1'b0; reg_en_i = 1'b0;
    compare_all();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      reset_i     = ($urandom_range(0, 99) < 3);
      cnt_clear_i = ($urandom_range(0, 99) < 10);
      cnt_up_i    = ($urandom_range(0, 99) < 70);
      reg_en_i    = $urandom_range(0, 1) == 1;
      reg_data_i  = {$urandom, $urandom};
      pack_data_i = {$urandom, $urandom};
      pack_size_i = 2'($urandom_range(0, 3));
      pack_sel_i  = 3'($urandom_range(0, 7));
      #1;
      compare_all();
      cycle();
    end
    compare_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_pack_datapath.md
# bus_pack_datapath

Small datapath block bundling three reusable primitives: a combinational bus packer that extracts an aligned sub-word and replicates it across a wider bus, a clear/up counter, and an enabled reset register. It sits in the NBF-style loader datapath: the counter indexes the command stream, the register captures expected read data, and the packer drives the forward data bus.

## Interface
- in_width_p, 64: packer input width in bits; power of two, ≥ 8.
- out_width_p, 64: packer output width; multiple of in_width_p, ≥ in_width_p.
- max_val_p, 2**24-1: counter maximum value.
- init_val_p, 0: counter value after reset.
- reg_width_p, 64: register width.
- reg_reset_val_p, 0: register value after reset.
- Derived: sel_w = clog2(in_width_p/8) (min 1); size_w = clog2(sel_w) (min 1); cnt_w = clog2(max_val_p+1).
- clk_i  in  1  clock; single clock domain.
- reset_i  in  1  synchronous, active-high reset.
- pack_data_i  in  in_width_p  source word.
- pack_sel_i  in  sel_w  byte offset of the element.
- pack_size_i  in  size_w  log2 of element bytes (0=1B … log2(in_width_p/8)=full word).
- pack_data_o  out  out_width_p  replicated element.
- cnt_clear_i  in  1  clear counter.
- cnt_up_i  in  1  increment counter.
- cnt_o  out  cnt_w  counter value.
- reg_en_i  in  1  register load enable.
- reg_data_i  in  reg_width_p  register input.
- reg_data_o  out  reg_width_p  register output.

## Operation
- Packer: shifted = pack_data_i >> (8*pack_sel_i); element = low 8*2^pack_size_i bits of shifted; pack_data_o = element repeated out_width_p/(8*2^size) times. Callers keep sel aligned to size; misaligned sel is still a plain byte shift (bytes above the word read as 0).
- pack_size_i larger than log2(in_width_p/8) clamps to full word.
- Counter: next = (cnt_clear_i ? 0 : cnt_o) + cnt_up_i. Clear+up in the same cycle yields 1. Increment at max_val_p wraps modulo 2^cnt_w (error condition, see Configuration).
- Register: loads reg_data_i when reg_en_i; holds otherwise.

## Timing
- Packer purely combinational, zero latency; no state.
- Counter and register update on rising clk_i; outputs registered, visible the cycle after the input.
- Reset priority over clear, up and enable. During reset: cnt_o → init_val_p, reg_data_o → reg_reset_val_p, both from the first edge with reset_i high. pack_data_o unaffected by reset.
- Reset asserted mid-count discards the count; first increment after deassertion produces init_val_p+1.

## Configuration
- BUS_PACK_DATAPATH_ASSERT_EN defined: simulation-only checks — error on counter increment at max_val_p without clear; error if pack_sel_i not a multiple of 2^pack_size_i; elaboration error if out_width_p % in_width_p ≠ 0 or in_width_p not a power of two. Checks suppressed while reset_i is high.
- Undefined: no checks; functional behaviour identical (wrap, plain shift).

## Structure
- Shared package: size encoding enum (size_1/2/4/8/… = 0/1/2/3), width-derivation helpers for sel_w/size_w.
- One natural sub-module: bus_pack_replicate (combinational packer); counter and register stay inline.

## Test plan
- Packer, in=out=64, data 0x0123456789ABCDEF: size 0 sel 0 → 0xEFEFEFEFEFEFEFEF; size 1 sel 2 → 0x89AB89AB89AB89AB; size 2 sel 4 → 0x0123456701234567; size 3 sel 0 → 0x0123456789ABCDEF.
- Packer, out=128, size 3 → 0x0123456789ABCDEF0123456789ABCDEF.
- Counter: reset → 0; up for 3 cycles → 3; clear+up → 1; clear alone → 0; no inputs → holds.
- Counter wrap, max_val_p=7: at 7, up → 0; error reported only with macro defined.
- Register: reset → 0; en=1 data 0xDEADBEEF → next cycle 0xDEADBEEF; en=0 new data → holds; reset with en=1 → 0.
- Reset mid-operation: counter at 5, reset one cycle with up=1 → 0, then up → 1.
